sig_conditioner: RTL and testbench

Input front end for the frequency counter. It synchronises the raw external signal into the clk domain and removes glitches with a qualification filter. It then produces a one-cycle toggle pulse on every filtered transition. That pulse is the 1-bit sample stream fed to the moving-average stage. Rise/fall strobes and a saturating edge counter are also provided for debug readout.

---
 rtl/sig_conditioner.sv | 130 +++++++++++++
 tb/tb_sig_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sig_conditioner.sv
// rtl/sig_conditioner.sv - sync + deglitch front end with edge pulses and saturating edge counter
// Optional macro SIG_COND_DEGLITCH_EN enables the FILTER_LEN qualification FSM.
module sig_conditioner #(
  parameter int FILTER_LEN = 3,
  parameter int EDGE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig,
  input  logic              clr,
  output logic              sig_f,
  output logic              edge_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              edge_sat
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("sig_conditioner: FILTER_LEN must be in 1..15");
  end

  logic s1;
  logic s2;
  logic flip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
    end
  end

`ifdef SIG_COND_DEGLITCH_EN
  typedef enum logic {IDLE, QUAL} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] q;
  logic [3:0] q_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= 4'd0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
    end
  end

  // New level must hold FILTER_LEN synchronised samples; any return to sig_f drops the attempt.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    flip      = 1'b0;
    case (state)
      IDLE: begin
        q_nxt = 4'd0;
        if (s2 != sig_f) begin
          if (FILTER_LEN == 1) begin
            flip = 1'b1;
          end else begin
            state_nxt = QUAL;
            q_nxt     = 4'd1;
          end
        end
      end
      QUAL: begin
        if (s2 == sig_f) begin
          state_nxt = IDLE;
          q_nxt     = 4'd0;
        end else if (q == 4'(FILTER_LEN - 1)) begin
          flip      = 1'b1;
          state_nxt = IDLE;
          q_nxt     = 4'd0;
        end else begin
          q_nxt = q + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = 4'd0;
      end
    endcase
  end
`else
  always_comb begin
    flip = (s2 != sig_f);
  end
`endif

  // On a flip the new level is s2, so rise/fall follow directly from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_f  <= 1'b0;
      edge_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      edge_o <= flip;
      rise_o <= flip & s2;
      fall_o <= flip & ~s2;
      if (flip) begin
        sig_f <= s2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt <= '0;
      edge_sat <= 1'b0;
    end else if (clr) begin
      edge_cnt <= EDGE_W'(edge_o);
      edge_sat <= 1'b0;
    end else begin
      if (edge_o && !(&edge_cnt)) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
      if (&edge_cnt) begin
        edge_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sig_conditioner.sv
// tb/tb_sig_conditioner.sv - directed self-checking bench for sig_conditioner
// Follows SIG_COND_DEGLITCH_EN to pick the expected latency and filter scenarios.
module tb_sig_conditioner;

`ifdef SIG_COND_DEGLITCH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sig_a, clr_a, sig_b, clr_b;
  logic       sig_f_a, edge_a, rise_a, fall_a, sat_a;
  logic [7:0] cnt_a;
  logic       sig_f_b, edge_b, rise_b, fall_b, sat_b;
  logic [3:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sig_conditioner #(.FILTER_LEN(3), .EDGE_W(8)) u_a (
    .clk(clk), .reset(reset), .sig(sig_a), .clr(clr_a),
    .sig_f(sig_f_a), .edge_o(edge_a), .rise_o(rise_a), .fall_o(fall_a),
    .edge_cnt(cnt_a), .edge_sat(sat_a)
  );

  sig_conditioner #(.FILTER_LEN(1), .EDGE_W(4)) u_b (
    .clk(clk), .reset(reset), .sig(sig_b), .clr(clr_b),
    .sig_f(sig_f_b), .edge_o(edge_b), .rise_o(rise_b), .fall_o(fall_b),
    .edge_cnt(cnt_b), .edge_sat(sat_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    sig_a = 1'b0; clr_a = 1'b0;
    sig_b = 1'b0; clr_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sig_f_a", 32'(sig_f_a), 0);
    check("rst_edge_a", 32'(edge_a), 0);
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_sat_a", 32'(sat_a), 0);
    check("rst_edge_b", 32'(edge_b), 0);
    check("rst_cnt_b", 32'(cnt_b), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // single rising then falling transition
    sig_a = 1'b1;
    repeat (LAT) @(negedge clk);
    check("t1_pre_sig_f", 32'(sig_f_a), 0);
    check("t1_pre_edge", 32'(edge_a), 0);
    @(negedge clk);
    check("t1_sig_f", 32'(sig_f_a), 1);
    check("t1_edge", 32'(edge_a), 1);
    check("t1_rise", 32'(rise_a), 1);
    check("t1_fall", 32'(fall_a), 0);
    @(negedge clk);
    check("t1_edge_low", 32'(edge_a), 0);
    check("t1_rise_low", 32'(rise_a), 0);
    check("t1_cnt", 32'(cnt_a), 1);
    sig_a = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("t1_fall", 32'(fall_a), 1);
    check("t1_fall_rise", 32'(rise_a), 0);
    check("t1_fall_sig_f", 32'(sig_f_a), 0);
    @(negedge clk);
    check("t1_cnt2", 32'(cnt_a), 2);
    check("t1_fall_low", 32'(fall_a), 0);

    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("clr_cnt", 32'(cnt_a), 0);
    check("clr_sat", 32'(sat_a), 0);

`ifdef SIG_COND_DEGLITCH_EN
    sig_a = 1'b1;
    repeat (2) @(negedge clk);
    sig_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("glitch_edge", 32'(edge_a), 0);
      check("glitch_sig_f", 32'(sig_f_a), 0);
    end
    sig_a = 1'b1;
    repeat (3) @(negedge clk);
    sig_a = 1'b0;
    repeat (2) @(negedge clk);
    check("q3_rise", 32'(rise_a), 1);
    check("q3_sig_f", 32'(sig_f_a), 1);
    repeat (2) @(negedge clk);
    check("q3_gap_edge", 32'(edge_a), 0);
    @(negedge clk);
    check("q3_fall", 32'(fall_a), 1);
    check("q3_sig_f_low", 32'(sig_f_a), 0);
    @(negedge clk);
    check("q3_cnt", 32'(cnt_a), 2);
`else
    sig_a = 1'b1;
    @(negedge clk);
    sig_a = 1'b0;
    @(negedge clk);
    check("p1_pre_sig_f", 32'(sig_f_a), 0);
    @(negedge clk);
    check("p1_sig_f", 32'(sig_f_a), 1);
    check("p1_rise", 32'(rise_a), 1);
    @(negedge clk);
    check("p1_sig_f_low", 32'(sig_f_a), 0);
    check("p1_fall", 32'(fall_a), 1);
    check("p1_edge", 32'(edge_a), 1);
    @(negedge clk);
    check("p1_edge_low", 32'(edge_a), 0);
    check("p1_cnt", 32'(cnt_a), 2);
`endif

    // asynchronous reset in the middle of a qualification
    sig_a = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_sig_f", 32'(sig_f_a), 0);
    check("arst_edge", 32'(edge_a), 0);
    check("arst_rise", 32'(rise_a), 0);
    check("arst_cnt", 32'(cnt_a), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      check("rel_rise", 32'(rise_a), 32'(i == LAT + 1));
      check("rel_sig_f", 32'(sig_f_a), 32'(i >= LAT + 1));
    end
    check("rel_cnt", 32'(cnt_a), 1);

    // FILTER_LEN=1, 4-bit counter: toggle every cycle until saturation, then clear
    for (int j = 1; j <= 25; j++) begin
      sig_b = j[0];
      clr_b = (j == 25);
      @(negedge clk);
      if (j >= 3) begin
        check("tog_edge", 32'(edge_b), 1);
        check("tog_rise", 32'(rise_b), 32'(j[0]));
        check("tog_fall", 32'(fall_b), 32'(!j[0]));
      end
      if (j == 18) begin
        check("sat_cnt15", 32'(cnt_b), 15);
        check("sat_lag", 32'(sat_b), 0);
      end
      if (j == 24) begin
        check("sat_hold", 32'(cnt_b), 15);
        check("sat_set", 32'(sat_b), 1);
      end
    end
    clr_b = 1'b0;
    check("clr_edge_cnt", 32'(cnt_b), 1);
    check("clr_edge_sat", 32'(sat_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
